// File: rtl/datapath_trace_buffer.sv
// ----------------------------------------------------------------------------
// datapath_trace_buffer
//
// Trigger-based trace capture for the processor debug datapath. While armed,
// every qualified cycle stores {instr, aluResult, alu_op, jump, ifbranch} into
// a circular buffer. An instruction that matches trig_val under trig_mask
// starts a post-trigger countdown of POST_TRIG samples. When the countdown
// ends the buffer freezes, and the history can be read out oldest first.
//
// Optional feature macro: TRACE_TIMESTAMP_EN
//   When defined, a TS_W-bit cycle counter runs while capturing. Its value is
//   stored in the MSBs of every entry.
//
// Ports
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   arm_i          pulse: clear the buffer and start capture
//   cap_valid_i    current-cycle sample is valid
//   instr_i        sampled instruction
//   alu_result_i   sampled ALU result
//   alu_op_i       sampled ALU op
//   jump_i         sampled jump flag
//   ifbranch_i     sampled branch-taken flag
//   trig_mask_i    trigger compare mask over instr
//   trig_val_i     trigger compare value
//   rd_en_i        readout request, honoured only in DONE
//   state_o        0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   done_o         high in DONE
//   fill_cnt_o     number of valid entries, saturates at DEPTH
//   trig_pos_o     readout index of the trigger sample
//   rd_valid_o     rd_data_o is valid this cycle
//   rd_data_o      {ts, instr, alu_result, alu_op, jump, ifbranch}
//   rd_last_o      marks the final entry of the readout
// ----------------------------------------------------------------------------
module datapath_trace_buffer #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 8,
   parameter int TS_W      = 16,
   localparam int AW       = $clog2(DEPTH),
`ifdef TRACE_TIMESTAMP_EN
   localparam int E        = 2*DATA_W + 4 + TS_W
`else
   localparam int E        = 2*DATA_W + 4
`endif
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              arm_i,
   input  logic              cap_valid_i,
   input  logic [DATA_W-1:0] instr_i,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic [1:0]        alu_op_i,
   input  logic              jump_i,
   input  logic              ifbranch_i,
   input  logic [DATA_W-1:0] trig_mask_i,
   input  logic [DATA_W-1:0] trig_val_i,
   input  logic              rd_en_i,
   output logic [1:0]        state_o,
   output logic              done_o,
   output logic [AW:0]       fill_cnt_o,
   output logic [AW-1:0]     trig_pos_o,
   output logic              rd_valid_o,
   output logic [E-1:0]      rd_data_o,
   output logic              rd_last_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] POST_C  = AW'(POST_TRIG);

   state_t          state_q;
   logic [AW-1:0]   wrPtr_q, wrPtr_d;
   logic [AW-1:0]   rdPtr_q;
   logic [AW-1:0]   postCnt_q;
   logic [AW-1:0]   trigPos_q, trigPos_d;
   logic [AW-1:0]   doneRdPtr;
   logic [AW:0]     fillCnt_q, fillCnt_d;
   logic [AW:0]     rdCnt_q;
   logic            rdValid_q, rdLast_q;
   logic [E-1:0]    rdData_q;
   logic [E-1:0]    mem [DEPTH];
   logic [E-1:0]    wrEntry;
   logic            hit, capturing, wrEn, rdFire;

   // A trigger only counts on a qualified sample; arm in the same cycle
   // suppresses both capture and readout.
   assign hit       = cap_valid_i && ((instr_i & trig_mask_i) == (trig_val_i & trig_mask_i));
   assign capturing = (state_q == ARMED) || (state_q == POST);
   assign wrEn      = capturing && cap_valid_i && !arm_i;
   assign rdFire    = (state_q == DONE) && rd_en_i && (rdCnt_q < fillCnt_q) && !arm_i;

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;

   // Free-running capture timestamp, restarted by every arm.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ts_q <= '0;
      end else if (arm_i) begin
         ts_q <= '0;
      end else if (capturing) begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   assign wrEntry = {ts_q, instr_i, alu_result_i, alu_op_i, jump_i, ifbranch_i};
`else
   assign wrEntry = {instr_i, alu_result_i, alu_op_i, jump_i, ifbranch_i};
`endif

   // Next write pointer and fill level. The write pointer wraps naturally
   // because DEPTH is a power of two. The trigger position and readout start
   // are derived from these post-write values, because the final write
   // lands on the same edge that enters DONE.
   always_comb begin
      wrPtr_d   = wrPtr_q;
      fillCnt_d = fillCnt_q;
      if (wrEn) begin
         wrPtr_d = wrPtr_q + AW'(1);
         if (fillCnt_q != DEPTH_C) begin
            fillCnt_d = fillCnt_q + (AW+1)'(1);
         end
      end
      trigPos_d = fillCnt_d[AW-1:0] - AW'(1) - POST_C;
      doneRdPtr = (fillCnt_d < DEPTH_C) ? '0 : wrPtr_d;
   end

   // Trace storage. It needs no reset, because fill_cnt decides which
   // entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (wrEn) begin
         mem[wrPtr_q] <= wrEntry;
      end
   end

   // Control FSM and readout path. Arm overrides everything else: it clears
   // all pointers, drops any readout in flight and re-enters ARMED.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         postCnt_q <= '0;
         trigPos_q <= '0;
         fillCnt_q <= '0;
         rdCnt_q   <= '0;
         rdValid_q <= 1'b0;
         rdLast_q  <= 1'b0;
         rdData_q  <= '0;
      end else if (arm_i) begin
         state_q   <= ARMED;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         postCnt_q <= '0;
         trigPos_q <= '0;
         fillCnt_q <= '0;
         rdCnt_q   <= '0;
         rdValid_q <= 1'b0;
         rdLast_q  <= 1'b0;
      end else begin
         wrPtr_q   <= wrPtr_d;
         fillCnt_q <= fillCnt_d;
         rdValid_q <= rdFire;
         rdLast_q  <= 1'b0;
         if (rdFire) begin
            rdData_q <= mem[rdPtr_q];
            rdLast_q <= (rdCnt_q == fillCnt_q - (AW+1)'(1));
            rdPtr_q  <= rdPtr_q + AW'(1);
            rdCnt_q  <= rdCnt_q + (AW+1)'(1);
         end
         case (state_q)
            ARMED: begin
               if (hit) begin
                  if (POST_C == '0) begin
                     state_q   <= DONE;
                     trigPos_q <= trigPos_d;
                     rdPtr_q   <= doneRdPtr;
                     rdCnt_q   <= '0;
                  end else begin
                     state_q   <= POST;
                     postCnt_q <= POST_C;
                  end
               end
            end
            POST: begin
               if (cap_valid_i) begin
                  postCnt_q <= postCnt_q - AW'(1);
                  if (postCnt_q == AW'(1)) begin
                     state_q   <= DONE;
                     trigPos_q <= trigPos_d;
                     rdPtr_q   <= doneRdPtr;
                     rdCnt_q   <= '0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign state_o    = state_q;
   assign done_o     = (state_q == DONE);
   assign fill_cnt_o = fillCnt_q;
   assign trig_pos_o = trigPos_q;
   assign rd_valid_o = rdValid_q;
   assign rd_data_o  = rdData_q;
   assign rd_last_o  = rdLast_q;

endmodule
